// File: rtl/swo_uart_pkg.sv
// Shared types and constants for the SWO UART receiver: FSM states,
// default oversampling ratio and the sample indices used for bit voting.
package swo_uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_WAIT_HIGH
    } rx_state_t;

    localparam int unsigned OVERSAMPLE_DFLT = 16;

    localparam int unsigned VOTE_IDX_A = 7;
    localparam int unsigned VOTE_IDX_B = 8;
    localparam int unsigned VOTE_IDX_C = 9;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous shift-register FIFO: head entry is always slot 0, so the
// read data comes straight from a register.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    output logic             full_o,
    output logic             pop_valid_o,
    output logic [WIDTH-1:0] pop_data_o,
    input  logic             pop_ready_i
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [CW-1:0]    count_q, count_d;
    logic             valid_q, full_q;
    logic             pop_c, push_ok_c;
    logic [AW-1:0]    wr_idx_c;

    // A push into a full FIFO is accepted only when a pop frees a slot.
    assign pop_c     = valid_q && pop_ready_i;
    assign push_ok_c = push_i && (!full_q || pop_c);
    assign wr_idx_c  = pop_c ? AW'(count_q - CW'(1)) : AW'(count_q);

    always_comb begin
        mem_d = mem_q;
        if (pop_c) begin
            for (int i = 0; i < int'(DEPTH) - 1; i++) begin
                mem_d[AW'(i)] = mem_q[AW'(i + 1)];
            end
            mem_d[AW'(DEPTH - 1)] = '0;
        end
        if (push_ok_c) begin
            mem_d[wr_idx_c] = push_data_i;
        end
        count_d = count_q + CW'(push_ok_c) - CW'(pop_c);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q   <= '{default: '0};
            count_q <= '0;
            valid_q <= 1'b0;
            full_q  <= 1'b0;
        end else begin
            mem_q   <= mem_d;
            count_q <= count_d;
            valid_q <= (count_d != '0);
            full_q  <= (count_d == CW'(DEPTH));
        end
    end

    assign full_o      = full_q;
    assign pop_valid_o = valid_q;
    assign pop_data_o  = mem_q[0];

endmodule

// File: rtl/swo_uart_rx.sv
// Oversampling 8N1 receiver for the SWO trace line with majority voting,
// frame/break/overrun reporting and an output byte FIFO.
module swo_uart_rx
    import swo_uart_pkg::*;
#(
    parameter int unsigned OVERSAMPLE = OVERSAMPLE_DFLT,
    parameter int unsigned DIV_WIDTH  = 16,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    input  logic                 enable,
    input  logic [DIV_WIDTH-1:0] div,
    output logic [7:0]           m_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 break_det,
    output logic                 busy
);
    localparam int unsigned SW = $clog2(OVERSAMPLE);

    logic                 sync1_q, rx_s_q;
    logic [DIV_WIDTH-1:0] div_cnt_q;
    rx_state_t            state_q;
    logic [SW-1:0]        sample_cnt_q;
    logic [2:0]           bit_cnt_q;
    logic [7:0]           shift_q;
    logic                 vote_a_q, vote_b_q;
    logic                 busy_q, frame_err_q, break_q, overrun_q;
    logic                 tick_c, start_c, vote_c, decide_c, push_c;
    logic                 fifo_full;

    assign tick_c   = (div_cnt_q == '0);
    assign start_c  = (state_q == ST_IDLE) && enable && !rx_s_q;
    assign vote_c   = majority3(vote_a_q, vote_b_q, rx_s_q);
    assign decide_c = tick_c && (sample_cnt_q == SW'(VOTE_IDX_C));
    assign push_c   = enable && decide_c && (state_q == ST_STOP) && vote_c;

    // Line synchronizer and sample-tick divider (restarted at each frame start).
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q   <= 1'b1;
            rx_s_q    <= 1'b1;
            div_cnt_q <= div;
        end else begin
            sync1_q <= rx;
            rx_s_q  <= sync1_q;
            if (!enable || start_c || tick_c) begin
                div_cnt_q <= div;
            end else begin
                div_cnt_q <= div_cnt_q - DIV_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        frame_err_q <= 1'b0;
        break_q     <= 1'b0;
        if (rst || !enable) begin
            state_q      <= ST_IDLE;
            busy_q       <= 1'b0;
            sample_cnt_q <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            vote_a_q     <= 1'b1;
            vote_b_q     <= 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_c) begin
                        state_q      <= ST_START;
                        busy_q       <= 1'b1;
                        sample_cnt_q <= '0;
                        bit_cnt_q    <= '0;
                    end
                end
                ST_WAIT_HIGH: begin
                    if (rx_s_q) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    if (tick_c) begin
                        sample_cnt_q <= (sample_cnt_q == SW'(OVERSAMPLE - 1)) ? '0
                                      : sample_cnt_q + SW'(1);
                        if (sample_cnt_q == SW'(VOTE_IDX_A)) vote_a_q <= rx_s_q;
                        if (sample_cnt_q == SW'(VOTE_IDX_B)) vote_b_q <= rx_s_q;
                    end
                    // Bit decisions happen on the third vote sample.
                    if (decide_c) begin
                        case (state_q)
                            ST_START: begin
                                if (vote_c) begin
                                    state_q <= ST_IDLE;
                                    busy_q  <= 1'b0;
                                end else begin
                                    state_q <= ST_DATA;
                                end
                            end
                            ST_DATA: begin
                                shift_q   <= {vote_c, shift_q[7:1]};
                                bit_cnt_q <= bit_cnt_q + 3'd1;
                                if (bit_cnt_q == 3'd7) state_q <= ST_STOP;
                            end
                            ST_STOP: begin
                                if (vote_c) begin
                                    state_q <= ST_IDLE;
                                    busy_q  <= 1'b0;
                                end else begin
                                    state_q <= ST_WAIT_HIGH;
                                    if (shift_q == 8'h00) break_q     <= 1'b1;
                                    else                  frame_err_q <= 1'b1;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) overrun_q <= 1'b0;
        else     overrun_q <= push_c && fifo_full && !(m_valid && m_ready);
    end

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push_c),
        .push_data_i (shift_q),
        .full_o      (fifo_full),
        .pop_valid_o (m_valid),
        .pop_data_o  (m_data),
        .pop_ready_i (m_ready)
    );

    assign frame_err = frame_err_q;
    assign break_det = break_q;
    assign overrun   = overrun_q;
    assign busy      = busy_q;

endmodule

// File: doc/swo_uart_rx.md
SWO_UART_RX -- requirements
Module: swo_uart_rx

Interface
REQ-001 SHALL have parameter OVERSAMPLE, default 16, sample ticks per bit.
REQ-002 SHALL have parameter DIV_WIDTH, default 16, width of divisor input.
REQ-003 SHALL have parameter FIFO_DEPTH, default 8, byte FIFO entries, power of two.
REQ-004 SHALL have port clk, input, 1, clock.
REQ-005 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-006 SHALL have port rx, input, 1, asynchronous serial line, idle high.
REQ-007 SHALL have port enable, input, 1, receiver enable.
REQ-008 SHALL have port div, input, DIV_WIDTH, clocks per sample tick minus 1.
REQ-009 SHALL have port m_data, output, 8, FIFO head byte.
REQ-010 SHALL have port m_valid, output, 1, FIFO non-empty.
REQ-011 SHALL have port m_ready, input, 1, consumer accepts m_data.
REQ-012 SHALL have port frame_err, output, 1, one-clk pulse on bad stop bit.
REQ-013 SHALL have port overrun, output, 1, one-clk pulse on byte dropped because FIFO full.
REQ-014 SHALL have port break_det, output, 1, one-clk pulse on break.
REQ-015 SHALL have port busy, output, 1, high whenever FSM is not IDLE.

Function
REQ-016 SHALL pass rx through a 2-flop synchronizer (rx_s); both flops reset to 1.
REQ-017 SHALL produce a sample tick once every div+1 clks (div=0: every clk); divider reloads with div whenever enable=0 or the FSM leaves IDLE.
REQ-018 SHALL use FSM states IDLE, START, DATA, STOP, WAIT_HIGH; sample counter 0..OVERSAMPLE-1 per bit.
REQ-019 SHALL leave IDLE for START on the first clk with rx_s=0 and enable=1.
REQ-020 SHALL decide each bit by 2-of-3 majority of the samples at indices 7, 8, 9.
REQ-021 SHALL, in START at index 9, go to DATA on majority 0, else return to IDLE with no flag (false start).
REQ-022 SHALL shift 8 data bits LSB first in DATA, then enter STOP.
REQ-023 SHALL, in STOP at index 9: majority 1 -> push byte, enter IDLE (half-bit resync); majority 0 with data 0x00 -> pulse break_det, enter WAIT_HIGH; majority 0 otherwise -> pulse frame_err, discard byte, enter WAIT_HIGH.
REQ-024 SHALL leave WAIT_HIGH for IDLE on the first clk with rx_s=1.
REQ-025 SHALL assert m_valid with the pushed byte 1 clk after the stop-bit decision when FIFO was empty.
REQ-026 SHALL pop on m_valid&&m_ready; m_data stable while m_valid&&!m_ready.
REQ-027 SHALL on push while full with no pop drop the new byte, pulse overrun, keep FIFO contents.
REQ-028 SHALL on simultaneous push and pop while full accept the push, no overrun.
REQ-029 SHALL on simultaneous push and pop while empty-then-valid keep count unchanged, order preserved.
REQ-030 SHALL on enable=0 force FSM to IDLE next clk, abort any frame without flags, keep FIFO contents and keep servicing pops.
REQ-031 SHALL ignore div changes mid-frame until next reload; div is static during a frame by contract.

Reset
REQ-032 SHALL on rst: FSM IDLE, FIFO empty, m_valid=0, m_data=0, frame_err=0, overrun=0, break_det=0, busy=0, synchronizer=1, divider=div.
REQ-033 SHALL on rst mid-frame discard the partial byte with no flag pulse.

Structure
REQ-034 SHALL place state enum, OVERSAMPLE default and vote indices (7,8,9) in shared package swo_uart_pkg.
REQ-035 SHALL implement the byte FIFO as sub-module sync_fifo (parameterised width/depth, valid/ready pop, push/full).

Verification
REQ-036 SHALL test: div=2 (48 clk/bit), send 0x55 8N1 -> m_data=0x55, m_valid 1 clk after stop decision, no flags.
REQ-037 SHALL test: rx low for 4 ticks then high -> no byte, no flag, busy drops; also 0xC3 with one-tick glitch at index 8 of bit 2 -> 0xC3 received.
REQ-038 SHALL test: 0xA5 with stop bit 0 -> one frame_err pulse, FIFO unchanged, next 0x5A received.
REQ-039 SHALL test: m_ready=0, send 0x00..0x08 -> single overrun on 9th byte; drain yields 0x00..0x07 in order.
REQ-040 SHALL test: rx low 20 bit times -> exactly one break_det, no frame_err, no byte; after rx high, 0x7E received.
REQ-041 SHALL test: rst asserted mid-bit 4 of a frame -> all outputs at reset values next clk; following 0x3C received cleanly.
